// File: rtl/tlb_refill_walker_if.sv
// TLB miss request / refill response channel between the TLB and the refill walker.
// Latency: none; this is a bundle of wires with a direction view per side.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
interface tlb_refill_walker_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_vpage;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_vpage;
  logic [WIDTH-1:0] resp_ppage;
  logic             resp_fault;

  // TLB side: issues misses, consumes refills
  modport master (
    output req_valid, req_vpage, resp_ready,
    input  req_ready, resp_valid, resp_vpage, resp_ppage, resp_fault
  );

  // Walker side: accepts misses, produces refills
  modport slave (
    input  req_valid, req_vpage, resp_ready,
    output req_ready, resp_valid, resp_vpage, resp_ppage, resp_fault
  );
endinterface

// File: rtl/tlb_refill_walker.sv
// TLB refill walker: queues deduplicated miss pages, walks them, returns ppage = vpage + 1 and fault = (vpage == 0).
// Latency: accepted on an idle, empty block at edge A -> resp_valid high after edge A+2+WALK_DELAY.
// Backpressure: req_ready = queue not full (registered occupancy only); the response is held until resp_ready.
module tlb_refill_walker #(
  parameter int WIDTH       = 8,
  parameter int WALK_DELAY  = 3,
  parameter int DELAY_WIDTH = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  output logic o_busy,
  tlb_refill_walker_if.slave bus
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_INIT = DELAY_WIDTH'(WALK_DELAY);
  localparam logic [PTR_W-1:0]       LAST_SLOT  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0]       FULL_CNT   = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] r_qv;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [DELAY_WIDTH-1:0] r_delay;
  logic [WIDTH-1:0]       r_cur_vpage;
  logic [WIDTH-1:0]       r_resp_vpage;
  logic [WIDTH-1:0]       r_resp_ppage;
  logic                   r_resp_fault;
  logic                   w_full;
  logic                   w_dup;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_load_resp;

  assign w_full         = (r_count == FULL_CNT);
  assign bus.req_ready  = !w_full;
  assign w_push         = bus.req_valid && !w_full && !i_flush && !w_dup;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_vpage = r_resp_vpage;
  assign bus.resp_ppage = r_resp_ppage;
  assign bus.resp_fault = r_resp_fault;
  assign o_busy         = (r_state != S_IDLE) || (r_count != '0);

  // Duplicate detection against every live queue slot and the page currently walking/answering
  always_comb begin
    w_dup = (r_state != S_IDLE) && (r_cur_vpage == bus.req_vpage);
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (r_qv[i] && (r_q[i] == bus.req_vpage)) w_dup = 1'b1;
    end
  end

  // Queue payload storage; contents are only meaningful where r_qv is set
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= bus.req_vpage;
  end

  // Queue bookkeeping: pointers, per-slot valid bits and occupancy; flush empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qv     <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_qv     <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_qv[r_wr_ptr] <= 1'b1;
        r_wr_ptr       <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_qv[r_rd_ptr] <= 1'b0;
        r_rd_ptr       <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus pop/load strobes; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WALK;
        end
      end
      S_WALK: begin
        if (r_delay == '0) begin
          w_load_resp = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WALK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
      w_load_resp = 1'b0;
    end
  end

  // Walk datapath: current page, walk countdown and the registered response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_vpage  <= '0;
      r_delay      <= '0;
      r_resp_vpage <= '0;
      r_resp_ppage <= '0;
      r_resp_fault <= 1'b0;
    end else if (i_flush) begin
      r_delay <= '0;
    end else begin
      if (w_pop) begin
        r_cur_vpage <= r_q[r_rd_ptr];
        r_delay     <= DELAY_INIT;
      end else if ((r_state == S_WALK) && (r_delay != '0)) begin
        r_delay <= r_delay - 1'b1;
      end
      if (w_load_resp) begin
        r_resp_vpage <= r_cur_vpage;
        r_resp_ppage <= r_cur_vpage + 1'b1;
        r_resp_fault <= (r_cur_vpage == '0);
      end
    end
  end
endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: directed misses, expected refills queued and checked by a response monitor.
// Latency: clock period 10; inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: resp_ready toggled to stall the walker and fill its queue.
module tb_tlb_refill_walker;
  typedef struct packed {
    logic [7:0] vpage;
    logic [7:0] ppage;
    logic       fault;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   checks;
  int   failures;
  exp_t sb[$];

  tlb_refill_walker_if #(.WIDTH(8)) bus ();

  tlb_refill_walker #(
    .WIDTH(8), .WALK_DELAY(3), .DELAY_WIDTH(4), .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .o_busy(busy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every handshake must match the oldest expected refill
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual vpage=0x%0h required=no response", bus.resp_vpage);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_vpage", 32'(bus.resp_vpage), 32'(e.vpage));
        chk("resp_ppage", 32'(bus.resp_ppage), 32'(e.ppage));
        chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send(input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_vpage = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=req_ready stuck 0 required=accept vpage 0x%0h", v);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait until all expected responses are consumed and the block is idle
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_vpage  = 8'h00;
    bus.resp_ready = 1'b1;
    checks   = 0;
    failures = 0;

    // Reset state
    #3;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_vpage", 32'(bus.resp_vpage), 32'd0);
    chk("rst_resp_ppage", 32'(bus.resp_ppage), 32'd0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Latency: accept at A, resp_valid first high after edge A+5
    sb.push_back('{vpage: 8'h12, ppage: 8'h13, fault: 1'b0});
    send(8'h12);
    k = 99;
    for (int i = 0; i < 20 && k == 99; i++) begin
      @(negedge clk);
      if (bus.resp_valid) k = i;
    end
    chk("latency", 32'(k), 32'd5);
    drain("drain_basic");

    // Boundary pages: zero faults with ppage 1, all-ones wraps to 0
    sb.push_back('{vpage: 8'h00, ppage: 8'h01, fault: 1'b1});
    send(8'h00);
    sb.push_back('{vpage: 8'hFF, ppage: 8'h00, fault: 1'b0});
    send(8'hFF);
    drain("drain_boundary");

    // Stalled response holds; queue fills with 0x5,0x6 and then refuses 0x7
    bus.resp_ready = 1'b0;
    sb.push_back('{vpage: 8'h30, ppage: 8'h31, fault: 1'b0});
    send(8'h30);
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      @(negedge clk);
      if (bus.resp_valid) k = 1;
    end
    chk("stall_resp_up", 32'(k), 32'd1);
    tick();
    sb.push_back('{vpage: 8'h05, ppage: 8'h06, fault: 1'b0});
    send(8'h05);
    sb.push_back('{vpage: 8'h06, ppage: 8'h07, fault: 1'b0});
    send(8'h06);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {15'd0, bus.resp_valid, bus.resp_vpage, bus.resp_ppage, bus.resp_fault},
          {15'd0, 1'b1, 8'h30, 8'h31, 1'b0});
    end
    tick();
    bus.req_valid = 1'b1;
    bus.req_vpage = 8'h07;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    drain("drain_stall");

    // Duplicate of the walking page yields a single response
    sb.push_back('{vpage: 8'h20, ppage: 8'h21, fault: 1'b0});
    send(8'h20);
    send(8'h20);
    send(8'h20);
    drain("drain_dedup");

    // Flush during WALK with two queued entries
    send(8'h50);
    send(8'h51);
    send(8'h52);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy",       32'(busy),           32'd0);
    chk("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("flush_req_ready",  32'(bus.req_ready),  32'd1);
    for (int i = 0; i < 20; i++) tick();

    // Asynchronous reset in the middle of a walk
    send(8'h60);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_resp_vpage", 32'(bus.resp_vpage), 32'd0);
    chk("arst_resp_ppage", 32'(bus.resp_ppage), 32'd0);
    chk("arst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("arst_busy",       32'(busy),           32'd0);
    chk("arst_req_ready",  32'(bus.req_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
